// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generator, in-order pipelined imem interface
// and a DEPTH-entry prefetch FIFO feeding ID over valid/ready.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_inst,
    output logic [XLEN-1:0] id_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic            credit;
    logic            req_fire;
    logic            drop;
    logic            push;
    logic            pop;
    logic [CW-1:0]   outstanding_after_rsp;
    logic [XLEN-1:0] target;

    // Entries already buffered plus those still in flight may never exceed DEPTH.
    always_comb begin
        credit                = ({1'b0, count} + {1'b0, outstanding}) < {1'b0, FULL};
        imem_req_valid        = rst && credit && !redirect_valid;
        imem_addr             = fetch_pc;
        pc_out                = fetch_pc;
        req_fire              = imem_req_valid && imem_req_ready;
        drop                  = imem_rsp_valid && (drop_cnt != '0);
        push                  = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
        id_valid              = (count != '0) && !redirect_valid;
        pop                   = id_valid && id_ready;
        id_inst               = inst_mem[rd_ptr];
        id_pc                 = pc_mem[rd_ptr];
        outstanding_after_rsp = outstanding - CW'(imem_rsp_valid);
        target                = {redirect_pc[XLEN-1:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // Every request still in flight after this cycle belongs to the old path.
            fetch_pc    <= target;
            rsp_pc      <= target;
            outstanding <= outstanding_after_rsp;
            drop_cnt    <= outstanding_after_rsp;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (push) begin
                rsp_pc <= rsp_pc + XLEN'(4);
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            inst_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]   <= rsp_pc;
        end
    end

    assert property (@(posedge clk) disable iff (!rst) !(push && count == FULL));

endmodule
